// File: rtl/crypto_block_feeder_pkg.sv
// crypto_block_feeder_pkg
//   Shared definitions for the crypto_block byte-stream front end:
//   FSM state encoding and block geometry.
package crypto_block_feeder_pkg;

  localparam int BLOCK_BYTES = 16;
  localparam int BLOCK_W     = 128;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

endpackage

// File: rtl/crypto_byte_packer.sv
// crypto_byte_packer
//   Packs bytes big-endian into a 128-bit block. It holds the partial-block
//   shift register, the byte count, the zero-pad alignment, the loaded block
//   register and the pending-last flag.
//   Optional feature macro: CRYPTO_BLOCK_FEEDER_PAD_EN. When it is defined,
//   s_last ends a block early and the missing low-order bytes are zero-filled.
// Ports:
//   clk, reset  : clock, async active-high reset
//   byte_data   : input byte
//   byte_valid  : byte accepted this cycle (already gated by the feeder)
//   byte_last   : accepted byte is the last of the message
//   block_full  : this accepted byte completes a block (combinational pulse)
//   block_data  : completed block, registered, held until the next block loads
//   block_last  : pending-last flag of the loaded block
module crypto_byte_packer
  import crypto_block_feeder_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         byte_data,
  input  logic               byte_valid,
  input  logic               byte_last,
  output logic               block_full,
  output logic [BLOCK_W-1:0] block_data,
  output logic               block_last
);

  localparam logic [3:0] LAST_IDX = 4'(BLOCK_BYTES - 1);

  logic [BLOCK_W-9:0] shift_q;
  logic [3:0]         count_q;
  logic               ends_block;
  logic [6:0]         pad_shift;
  logic [BLOCK_W-1:0] packed_block;

`ifdef CRYPTO_BLOCK_FEEDER_PAD_EN
  assign ends_block = byte_last | (count_q == LAST_IDX);
`else
  assign ends_block = (count_q == LAST_IDX);
`endif

  assign block_full = byte_valid & ends_block;

  // Left-align the bytes of the current block. Bytes left over from an older
  // block sit above the current count and fall off the top of the shift,
  // and zeros fill in from the bottom.
  assign pad_shift    = {LAST_IDX - count_q, 3'b000};
  assign packed_block = {shift_q, byte_data} << pad_shift;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q    <= '0;
      count_q    <= '0;
      block_data <= '0;
      block_last <= 1'b0;
    end else if (byte_valid) begin
      if (ends_block) begin
        block_data <= packed_block;
        block_last <= byte_last;
        count_q    <= '0;
      end else begin
        shift_q <= {shift_q[BLOCK_W-17:0], byte_data};
        count_q <= count_q + 4'd1;
      end
    end
  end

endmodule

// File: rtl/crypto_block_feeder.sv
// crypto_block_feeder
//   Byte-stream front end for crypto_block. It packs 16 bytes into a block,
//   pulses cb_start with a stable key and block, and waits for cb_done. It then
//   presents the result on a valid/ready output stream. A watchdog flags a
//   core that never finishes.
//   Optional feature macro: CRYPTO_BLOCK_FEEDER_PAD_EN (see crypto_byte_packer).
// Parameters:
//   TIMEOUT_W : watchdog width; timeout after 2^TIMEOUT_W-1 cycles in WAIT
// Ports:
//   clk, reset               : clock, async active-high reset
//   key_in                   : cipher key, latched when a block completes
//   s_data/s_valid/s_last    : input byte stream, s_ready back-pressure
//   cb_start/cb_key/cb_data  : registered request to crypto_block
//   cb_result/cb_done        : crypto_block response
//   m_data/m_valid/m_last    : output block stream, m_ready back-pressure
//   timeout                  : sticky watchdog error
//
// state | meaning
// FILL  | accepting bytes into the packer
// START | one-cycle cb_start pulse
// WAIT  | waiting for cb_done, watchdog running
// OUT   | result held on m_data until m_ready
module crypto_block_feeder
  import crypto_block_feeder_pkg::*;
#(
  parameter int TIMEOUT_W = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [BLOCK_W-1:0] key_in,
  input  logic [7:0]         s_data,
  input  logic               s_valid,
  input  logic               s_last,
  output logic               s_ready,
  output logic               cb_start,
  output logic [BLOCK_W-1:0] cb_key,
  output logic [BLOCK_W-1:0] cb_data,
  input  logic [BLOCK_W-1:0] cb_result,
  input  logic               cb_done,
  output logic [BLOCK_W-1:0] m_data,
  output logic               m_valid,
  output logic               m_last,
  input  logic               m_ready,
  output logic               timeout
);

  // The counter enters WAIT at zero. Hitting this value on a cycle without
  // done means 2^TIMEOUT_W-1 WAIT cycles have elapsed.
  localparam logic [TIMEOUT_W-1:0] WDOG_LAST = TIMEOUT_W'((2 ** TIMEOUT_W) - 2);

  state_t               state;
  logic [TIMEOUT_W-1:0] wdog;
  logic                 byte_accept;
  logic                 block_full;
  logic                 block_last;

  assign s_ready     = (state == ST_FILL);
  assign byte_accept = s_valid & s_ready;

  crypto_byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .byte_data  (s_data),
    .byte_valid (byte_accept),
    .byte_last  (s_last),
    .block_full (block_full),
    .block_data (cb_data),
    .block_last (block_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_FILL;
      wdog     <= '0;
      cb_start <= 1'b0;
      cb_key   <= '0;
      m_data   <= '0;
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      case (state)
        ST_FILL: begin
          if (block_full) begin
            cb_key   <= key_in;
            cb_start <= 1'b1;
            state    <= ST_START;
          end
        end
        ST_START: begin
          cb_start <= 1'b0;
          wdog     <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cb_done) begin
            m_data  <= cb_result;
            m_last  <= block_last;
            m_valid <= 1'b1;
            state   <= ST_OUT;
          end else if (wdog == WDOG_LAST) begin
            timeout <= 1'b1;
            state   <= ST_FILL;
          end else begin
            wdog <= wdog + TIMEOUT_W'(1);
          end
        end
        ST_OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            state   <= ST_FILL;
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_crypto_block_feeder.sv
module tb_crypto_block_feeder;

  localparam int TW = 4;
  localparam logic [127:0] K1 = 128'hA5A5A5A5_5A5A5A5A_DEADBEEF_12345678;
  localparam logic [127:0] K2 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] K3 = 128'hFFFFFFFF_00000000_FFFFFFFF_00000000;
  localparam logic [127:0] D1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] D2 = 128'h10111213_14151617_18191A1B_1C1D1E1F;
  localparam logic [127:0] D3 = 128'h30313233_34353637_38393A3B_3C3D3E3F;
`ifdef CRYPTO_BLOCK_FEEDER_PAD_EN
  localparam logic [127:0] DP = 128'hAABBCC00_00000000_00000000_00000000;
`else
  localparam logic [127:0] DP = 128'hAABBCC01_02030405_06070809_0A0B0C0D;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in;
  logic [7:0]   s_data;
  logic         s_valid, s_last, s_ready;
  logic         cb_start;
  logic [127:0] cb_key, cb_data, cb_result;
  logic         cb_done;
  logic [127:0] m_data;
  logic         m_valid, m_last, m_ready, timeout;

  int n_checks  = 0;
  int n_fail    = 0;
  int start_cnt = 0;
  int mv_cnt    = 0;
  bit core_en   = 1'b1;

  always #5 clk = ~clk;

  crypto_block_feeder #(.TIMEOUT_W(TW)) dut (
    .clk       (clk),
    .reset     (rst),
    .key_in    (key_in),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .cb_start  (cb_start),
    .cb_key    (cb_key),
    .cb_data   (cb_data),
    .cb_result (cb_result),
    .cb_done   (cb_done),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .m_ready   (m_ready),
    .timeout   (timeout)
  );

  // behavioural core: data ^ key, done 5 cycles after start
  initial begin
    logic [127:0] res;
    cb_done   = 1'b0;
    cb_result = '0;
    forever begin
      @(posedge clk); #1;
      if (cb_start && core_en) begin
        res = cb_data ^ cb_key;
        repeat (4) @(posedge clk);
        #1;
        cb_result = res;
        cb_done   = 1'b1;
        @(posedge clk); #1;
        cb_done = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (cb_start) start_cnt++;
    if (m_valid) mv_cnt++;
  end

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // returns #1 after the edge that accepted the byte
  task automatic send_byte(input logic [7:0] d, input logic last);
    int n;
    n = 0;
    s_data  = d;
    s_valid = 1'b1;
    s_last  = last;
    @(negedge clk);
    while (s_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_eq("send_byte_stall", 128'(s_ready), 128'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] blk, input logic last);
    for (int i = 0; i < 16; i++)
      send_byte(blk[127-8*i -: 8], last && (i == 15));
  endtask

  // returns #1 after the edge that sampled cb_done
  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cb_done !== 1'b1 && n < 100);
    if (n >= 100) check_eq("wait_done_stall", 128'(cb_done), 128'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got stalled expected finish");
    $fatal(1, "bench stalled");
  end

  initial begin
    bit stable;
    int s0, mv0;
    rst = 1'b1; key_in = '0; s_data = '0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_s_ready", 128'(s_ready), 128'd1);
    check_eq("rst_cb_start", 128'(cb_start), 128'd0);
    check_eq("rst_m_valid", 128'(m_valid), 128'd0);
    check_eq("rst_m_last", 128'(m_last), 128'd0);
    check_eq("rst_timeout", 128'(timeout), 128'd0);
    check_eq("rst_cb_key", cb_key, 128'd0);
    check_eq("rst_cb_data", cb_data, 128'd0);
    check_eq("rst_m_data", m_data, 128'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // basic block, output held off for 10 cycles
    key_in = K1;
    send_block(D1, 1'b1);
    check_eq("t1_cb_start", 128'(cb_start), 128'd1);
    check_eq("t1_cb_data", cb_data, D1);
    check_eq("t1_cb_key", cb_key, K1);
    check_eq("t1_s_ready_start", 128'(s_ready), 128'd0);
    @(posedge clk); #1;
    check_eq("t1_start_one_cycle", 128'(cb_start), 128'd0);
    wait_done();
    check_eq("t1_m_valid", 128'(m_valid), 128'd1);
    check_eq("t1_m_data", m_data, D1 ^ K1);
    check_eq("t1_m_last", 128'(m_last), 128'd1);
    stable  = 1'b1;
    s_data  = 8'h77;
    s_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (m_data !== (D1 ^ K1) || s_ready !== 1'b0 || m_valid !== 1'b1) stable = 1'b0;
    end
    check_eq("t1_out_hold", 128'(stable), 128'd1);
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("t1_m_valid_drop", 128'(m_valid), 128'd0);
    check_eq("t1_s_ready_back", 128'(s_ready), 128'd1);
    m_ready = 1'b0;
    check_eq("t1_start_count", 128'(start_cnt), 128'd1);

    // key changes during WAIT, m_ready already high
    key_in  = K2;
    m_ready = 1'b1;
    send_block(D2, 1'b0);
    check_eq("t3_cb_key_latch", cb_key, K2);
    repeat (2) @(posedge clk);
    #1;
    key_in = K3;
    wait_done();
    check_eq("t3_cb_key_held", cb_key, K2);
    check_eq("t3_m_valid", 128'(m_valid), 128'd1);
    check_eq("t3_m_data", m_data, D2 ^ K2);
    check_eq("t3_m_last", 128'(m_last), 128'd0);
    @(posedge clk); #1;
    check_eq("t3_m_valid_drop", 128'(m_valid), 128'd0);
    check_eq("t3_s_ready", 128'(s_ready), 128'd1);
    m_ready = 1'b0;

    // hung core: watchdog
    core_en = 1'b0;
    key_in  = K1;
    mv0     = mv_cnt;
    send_block(D1, 1'b0);
    repeat (15) @(posedge clk);
    #1;
    check_eq("t4_timeout_early", 128'(timeout), 128'd0);
    check_eq("t4_s_ready_wait", 128'(s_ready), 128'd0);
    @(posedge clk); #1;
    check_eq("t4_timeout", 128'(timeout), 128'd1);
    check_eq("t4_back_fill", 128'(s_ready), 128'd1);
    check_eq("t4_no_m_valid", 128'(mv_cnt), 128'(mv0));
    core_en = 1'b1;

    // short message with s_last on the third byte
    s0 = start_cnt;
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b1);
`ifdef CRYPTO_BLOCK_FEEDER_PAD_EN
    check_eq("t5_pad_start", 128'(cb_start), 128'd1);
`else
    repeat (5) @(posedge clk);
    #1;
    check_eq("t5_no_start", 128'(start_cnt), 128'(s0));
    check_eq("t5_still_fill", 128'(s_ready), 128'd1);
    for (int i = 1; i <= 13; i++) send_byte(8'(i), i == 13);
    check_eq("t5_start", 128'(cb_start), 128'd1);
`endif
    check_eq("t5_cb_data", cb_data, DP);
    m_ready = 1'b1;
    wait_done();
    check_eq("t5_m_data", m_data, DP ^ K1);
    check_eq("t5_m_last", 128'(m_last), 128'd1);
    @(posedge clk); #1;
    m_ready = 1'b0;

    // reset in the middle of a partial block
    for (int i = 0; i < 7; i++) send_byte(8'(8'hE0 + i), 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t6_rst_timeout", 128'(timeout), 128'd0);
    check_eq("t6_rst_m_valid", 128'(m_valid), 128'd0);
    check_eq("t6_rst_cb_data", cb_data, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    send_block(D3, 1'b0);
    check_eq("t6_cb_data", cb_data, D3);
    check_eq("t6_timeout", 128'(timeout), 128'd0);
    m_ready = 1'b1;
    wait_done();
    check_eq("t6_m_data", m_data, D3 ^ K1);
    @(posedge clk); #1;
    m_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
